seq_shift_unit: RTL and testbench

//  Parametrised, multi-cycle shift/rotate unit. It generalises the fixed 4-bit

---
 rtl/seq_shift_unit_pkg.sv | 27 ++
 rtl/seq_shift_unit_shift_step.sv | 46 ++++
 rtl/seq_shift_unit.sv | 101 ++++++++++
 tb/tb_seq_shift_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_unit_pkg.sv
// Shared op codes, FSM state encoding and helpers for the sequential shift unit.
package seq_shift_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t SH_LOAD = 3'd0;
  localparam op_t SH_SHL  = 3'd1;
  localparam op_t SH_SHR  = 3'd2;
  localparam op_t SH_ASR  = 3'd3;
  localparam op_t SH_ROL  = 3'd4;
  localparam op_t SH_ROR  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True for op codes that take bit steps; LOAD and reserved codes do not.
  function automatic logic is_shift_op(input op_t op);
    return (op == SH_SHL) || (op == SH_SHR) || (op == SH_ASR) ||
           (op == SH_ROL) || (op == SH_ROR);
  endfunction

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// Combinational single-bit step of the shift/rotate datapath.
module shift_step
  import seq_shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [OP_W-1:0]  op,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_value,
  output logic             out_bit
);

  // Next register value and the bit that leaves it for the selected op.
  always_comb begin
    next_value = value;
    out_bit    = 1'b0;
    case (op)
      SH_SHL: begin
        next_value = {value[WIDTH-2:0], serial_in};
        out_bit    = value[WIDTH-1];
      end
      SH_SHR: begin
        next_value = {serial_in, value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      SH_ASR: begin
        next_value = {value[WIDTH-1], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      SH_ROL: begin
        next_value = {value[WIDTH-2:0], value[WIDTH-1]};
        out_bit    = value[WIDTH-1];
      end
      SH_ROR: begin
        next_value = {value[0], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      default: begin
        next_value = value;
        out_bit    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: one bit step per clock with start/busy/done handshake.
module seq_shift_unit
  import seq_shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] data_d;
  logic             carry_d;
  logic             busy_d;
  logic             done_d;
  logic [WIDTH-1:0] step_value;
  logic             step_bit;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .value      (data_out),
    .op         (op_q),
    .serial_in  (serial_in),
    .next_value (step_value),
    .out_bit    (step_bit)
  );

  // State, operand and handshake registers; reset discards any op in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      op_q      <= SH_LOAD;
      data_out  <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      data_out  <= data_d;
      carry_out <= carry_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state and datapath control; busy/done are registered decodes of the next state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    data_d  = data_out;
    carry_d = carry_out;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          data_d  = data_in;
          carry_d = 1'b0;
          count_d = amount;
          op_d    = op_t'(op);
          if ((amount == '0) || !is_shift_op(op_t'(op))) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        data_d  = step_value;
        carry_d = step_bit;
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed scoreboard bench for seq_shift_unit (WIDTH=8, AMT_W=4).
module tb_seq_shift_unit;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_ASR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_RSV  = 3'd7;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic [7:0] lat;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [3:0] amount;
  logic [7:0] data_in;
  logic       serial_in;
  logic [7:0] data_out;
  logic       carry_out;
  logic       busy;
  logic       done;

  int   errors;
  int   checks;
  exp_t exp_q[$];

  seq_shift_unit #(
    .WIDTH(8),
    .AMT_W(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .amount    (amount),
    .data_in   (data_in),
    .serial_in (serial_in),
    .data_out  (data_out),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Reference model: repeated single-bit steps using plain shift operators.
  function automatic exp_t model(input logic [2:0] o, input logic [3:0] a,
                                 input logic [7:0] d, input logic s);
    exp_t       r;
    logic [7:0] v;
    logic       c;
    logic       shifting;
    v = d;
    c = 1'b0;
    shifting = (o >= OP_SHL) && (o <= OP_ROR) && (a != 4'd0);
    if (shifting) begin
      for (int i = 0; i < int'(a); i++) begin
        case (o)
          OP_SHL: begin c = v[7]; v = (v << 1) | {7'd0, s}; end
          OP_SHR: begin c = v[0]; v = (v >> 1) | {s, 7'd0}; end
          OP_ASR: begin c = v[0]; v = 8'($signed(v) >>> 1); end
          OP_ROL: begin c = v[7]; v = (v << 1) | (v >> 7); end
          OP_ROR: begin c = v[0]; v = (v >> 1) | (v << 7); end
          default: ;
        endcase
      end
    end
    r.data  = v;
    r.carry = c;
    r.lat   = shifting ? 8'(a) : 8'd0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive a one-cycle start pulse; optionally record the expected result.
  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d,
                       input logic s, input bit push);
    op        = o;
    amount    = a;
    data_in   = d;
    serial_in = s;
    start     = 1'b1;
    if (push) exp_q.push_back(model(o, a, d, s));
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then compare latency, busy cycles and result.
  task automatic wait_done(input string tag, input int pre);
    int   n;
    int   b;
    exp_t e;
    n = pre;
    b = pre;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) b++;
      @(posedge clock);
      #1;
      n++;
    end
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " latency"}, 32'(n), 32'(e.lat));
      check({tag, " busy"}, 32'(b), 32'(e.lat));
      check({tag, " data"}, 32'(data_out), 32'(e.data));
      check({tag, " carry"}, 32'(carry_out), 32'(e.carry));
    end
  endtask

  task automatic step_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    op        = 3'd0;
    amount    = 4'd0;
    data_in   = 8'd0;
    serial_in = 1'b0;

    // Reset state
    step_cycles(2);
    check("rst data", 32'(data_out), 32'd0);
    check("rst carry", 32'(carry_out), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    reset = 1'b0;
    step_cycles(1);

    // SHL by 2, then done lasts one cycle only
    issue(OP_SHL, 4'd2, 8'b0000_0101, 1'b0, 1'b1);
    wait_done("shl2", 0);
    step_cycles(1);
    check("shl2 done pulse", 32'(done), 32'd0);
    check("shl2 hold", 32'(data_out), 32'h14);

    // SHL with serial fill, amount beyond width
    issue(OP_SHL, 4'd10, 8'b1010_0110, 1'b1, 1'b1);
    wait_done("shl10 fill", 0);
    step_cycles(1);

    // ASR short and saturating
    issue(OP_ASR, 4'd3, 8'b1000_0000, 1'b0, 1'b1);
    wait_done("asr3", 0);
    step_cycles(1);
    issue(OP_ASR, 4'd12, 8'b1000_0000, 1'b0, 1'b1);
    wait_done("asr12", 0);
    step_cycles(1);

    // Rotates, including wrap past WIDTH
    issue(OP_ROR, 4'd1, 8'b0000_0011, 1'b0, 1'b1);
    wait_done("ror1", 0);
    step_cycles(1);
    issue(OP_ROL, 4'd9, 8'b1000_0000, 1'b0, 1'b1);
    wait_done("rol9", 0);
    step_cycles(1);
    issue(OP_ROR, 4'd15, 8'b1100_1010, 1'b0, 1'b1);
    wait_done("ror15", 0);
    step_cycles(1);

    // LOAD, SHR by 0 and a reserved code all complete without shifting
    issue(OP_LOAD, 4'd5, 8'b1010_1010, 1'b0, 1'b1);
    wait_done("load", 0);
    step_cycles(1);
    issue(OP_SHR, 4'd0, 8'b1010_1010, 1'b1, 1'b1);
    wait_done("shr0", 0);
    step_cycles(1);
    issue(OP_RSV, 4'd3, 8'b0101_1100, 1'b1, 1'b1);
    wait_done("rsv", 0);
    step_cycles(1);

    // Reset in the middle of an SHR discards it immediately
    issue(OP_SHR, 4'd4, 8'b1111_0000, 1'b1, 1'b0);
    step_cycles(2);
    check("mid shr data", 32'(data_out), 32'(model(OP_SHR, 4'd2, 8'b1111_0000, 1'b1).data));
    check("mid shr busy", 32'(busy), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("async rst data", 32'(data_out), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst carry", 32'(carry_out), 32'd0);
    step_cycles(1);
    reset = 1'b0;
    step_cycles(1);
    check("post rst busy", 32'(busy), 32'd0);
    check("post rst done", 32'(done), 32'd0);
    issue(OP_SHR, 4'd3, 8'b1111_0000, 1'b1, 1'b1);
    wait_done("post rst shr3", 0);
    step_cycles(1);

    // Start while busy is ignored
    issue(OP_SHL, 4'd4, 8'b0000_0001, 1'b0, 1'b1);
    op        = OP_LOAD;
    amount    = 4'd0;
    data_in   = 8'hFF;
    start     = 1'b1;
    check("ignored busy", 32'(busy), 32'd1);
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done("ignored start", 1);

    // Start in DONE is taken with no IDLE cycle between ops
    issue(OP_ROL, 4'd3, 8'b1001_0001, 1'b0, 1'b1);
    wait_done("b2b first", 0);
    issue(OP_ASR, 4'd2, 8'b0100_0011, 1'b0, 1'b1);
    wait_done("b2b second", 0);
    issue(OP_LOAD, 4'd0, 8'h3C, 1'b0, 1'b1);
    wait_done("b2b load", 0);
    step_cycles(1);
    check("final idle done", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
